// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, constants and helpers for the sram2rw_param array
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int OUT_REG_NONE = 0;
    localparam int OUT_REG_ONE  = 1;

    // A two-word array still needs one address bit.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sram2rw_param_if.sv
// rtl/sram2rw_param_if.sv - per-port control, address and data bundle for sram2rw_param
interface sram2rw_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              CSB1_i, CSB2_i;
    logic              WEB1_i, WEB2_i;
    logic              OEB1_i, OEB2_i;
    logic [ADDR_W-1:0] A1_i, A2_i;
    logic [DATA_W-1:0] BWEB1_i, BWEB2_i;
    logic [DATA_W-1:0] I1_i, I2_i;
    logic              BUSY_i;
    logic              COLL_i;

    modport master (
        output CSB1_i, CSB2_i, WEB1_i, WEB2_i, OEB1_i, OEB2_i,
        output A1_i, A2_i, BWEB1_i, BWEB2_i, I1_i, I2_i,
        input  BUSY_i, COLL_i
    );

    modport slave (
        input  CSB1_i, CSB2_i, WEB1_i, WEB2_i, OEB1_i, OEB2_i,
        input  A1_i, A2_i, BWEB1_i, BWEB2_i, I1_i, I2_i,
        output BUSY_i, COLL_i
    );
endinterface

// File: rtl/sram_clear_fsm.sv
// rtl/sram_clear_fsm.sv - post-reset sweep that zeroes every word before user access
module sram_clear_fsm
    import sram_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              CE_i,
    input  logic              RSTB_i,
    output logic              BUSY_i,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    sram_state_e       state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge CE_i or negedge RSTB_i) begin
        if (!RSTB_i) begin
            state  <= CLEAR;
            cnt    <= '0;
            BUSY_i <= 1'b1;
            clr_we <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    // The edge that clears the last word also releases the array.
                    if (cnt == LAST) begin
                        state  <= READY;
                        BUSY_i <= 1'b0;
                        clr_we <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign clr_addr = cnt;
endmodule

// File: rtl/sram2rw_param.sv
// rtl/sram2rw_param.sv - two-port masked-write SRAM model; clear sweep under SRAM2RW_CLEAR_EN
module sram2rw_param
    import sram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = addr_w(DEPTH),
    parameter int OUT_REG = OUT_REG_NONE
) (
    input  logic              CE_i,
    input  logic              RSTB_i,
    sram2rw_param_if.slave    bus,
    output logic [DATA_W-1:0] O1_i,
    output logic [DATA_W-1:0] O2_i
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd2_q, d1, d2;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy, clr_we;
    logic              v1, v2, wr1, wr2, rd1, rd2, same;

`ifdef SRAM2RW_CLEAR_EN
    sram_clear_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clear (
        .CE_i     (CE_i),
        .RSTB_i   (RSTB_i),
        .BUSY_i   (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign bus.BUSY_i = busy;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign v1 = 1'b1;
            assign v2 = 1'b1;
        end else begin : g_part_range
            localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
            assign v1 = {1'b0, bus.A1_i} < DEPTH_L;
            assign v2 = {1'b0, bus.A2_i} < DEPTH_L;
        end
    endgenerate

    assign wr1  = ~busy & ~bus.CSB1_i & ~bus.WEB1_i & v1;
    assign wr2  = ~busy & ~bus.CSB2_i & ~bus.WEB2_i & v2;
    assign rd1  = ~busy & ~bus.CSB1_i &  bus.WEB1_i;
    assign rd2  = ~busy & ~bus.CSB2_i &  bus.WEB2_i;
    assign same = wr1 & wr2 & (bus.A1_i == bus.A2_i);

    always_ff @(posedge CE_i) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (same) begin
            // Port 1 owns every bit it unmasks; port 2 fills only bits port 1 leaves masked.
            mem[bus.A1_i] <= (mem[bus.A1_i] & bus.BWEB1_i & bus.BWEB2_i)
                           | (bus.I1_i & ~bus.BWEB1_i)
                           | (bus.I2_i & ~bus.BWEB2_i & bus.BWEB1_i);
        end else begin
            if (wr1) mem[bus.A1_i] <= (mem[bus.A1_i] & bus.BWEB1_i) | (bus.I1_i & ~bus.BWEB1_i);
            if (wr2) mem[bus.A2_i] <= (mem[bus.A2_i] & bus.BWEB2_i) | (bus.I2_i & ~bus.BWEB2_i);
        end
    end

    always_ff @(posedge CE_i or negedge RSTB_i) begin
        if (!RSTB_i) begin
            rd1_q      <= '0;
            rd2_q      <= '0;
            bus.COLL_i <= 1'b0;
        end else begin
            if (busy) begin
                rd1_q <= '0;
                rd2_q <= '0;
            end else begin
                if (rd1) rd1_q <= v1 ? mem[bus.A1_i] : 'x;
                if (rd2) rd2_q <= v2 ? mem[bus.A2_i] : 'x;
            end
            bus.COLL_i <= same;
        end
    end

    generate
        if (OUT_REG == OUT_REG_ONE) begin : g_oreg
            logic [DATA_W-1:0] o1_q, o2_q;
            always_ff @(posedge CE_i or negedge RSTB_i) begin
                if (!RSTB_i) begin
                    o1_q <= '0;
                    o2_q <= '0;
                end else begin
                    o1_q <= rd1_q;
                    o2_q <= rd2_q;
                end
            end
            assign d1 = o1_q;
            assign d2 = o2_q;
        end else begin : g_noreg
            assign d1 = rd1_q;
            assign d2 = rd2_q;
        end
    endgenerate

    assign O1_i = bus.OEB1_i ? 'z : d1;
    assign O2_i = bus.OEB2_i ? 'z : d2;
endmodule

// File: tb/tb_sram2rw_param.sv
// tb/tb_sram2rw_param.sv - directed bench for sram2rw_param, both output-stage variants in parallel
module tb_sram2rw_param;
`ifdef SRAM2RW_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk, rstb;
    logic        csb1, csb2, web1, web2, oeb1, oeb2;
    logic [5:0]  a1, a2;
    logic [31:0] bweb1, bweb2, i1, i2;
    wire  [31:0] o1_0, o2_0, o1_1, o2_1;
    int          n_checks = 0;
    int          n_err    = 0;
    bit          chk_en   = 0;

    sram2rw_param_if #(.DATA_W(32), .ADDR_W(6)) bus0 ();
    sram2rw_param_if #(.DATA_W(32), .ADDR_W(6)) bus1 ();

    assign bus0.CSB1_i = csb1;   assign bus1.CSB1_i = csb1;
    assign bus0.CSB2_i = csb2;   assign bus1.CSB2_i = csb2;
    assign bus0.WEB1_i = web1;   assign bus1.WEB1_i = web1;
    assign bus0.WEB2_i = web2;   assign bus1.WEB2_i = web2;
    assign bus0.OEB1_i = oeb1;   assign bus1.OEB1_i = oeb1;
    assign bus0.OEB2_i = oeb2;   assign bus1.OEB2_i = oeb2;
    assign bus0.A1_i = a1;       assign bus1.A1_i = a1;
    assign bus0.A2_i = a2;       assign bus1.A2_i = a2;
    assign bus0.BWEB1_i = bweb1; assign bus1.BWEB1_i = bweb1;
    assign bus0.BWEB2_i = bweb2; assign bus1.BWEB2_i = bweb2;
    assign bus0.I1_i = i1;       assign bus1.I1_i = i1;
    assign bus0.I2_i = i2;       assign bus1.I2_i = i2;

    sram2rw_param #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .OUT_REG(0)) u_dut0 (
        .CE_i(clk), .RSTB_i(rstb), .bus(bus0), .O1_i(o1_0), .O2_i(o2_0));
    sram2rw_param #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .OUT_REG(1)) u_dut1 (
        .CE_i(clk), .RSTB_i(rstb), .bus(bus1), .O1_i(o1_1), .O2_i(o2_1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: word array with per-word "contents defined" flags.
    logic [31:0] m_mem [64];
    bit          m_k   [64];
    logic [31:0] m_rd1, m_rd2, m_or1, m_or2;
    bit          m_rk1, m_rk2, m_ok1, m_ok2;
    bit          m_busy, m_coll;
    int          m_cnt;

    task automatic model_reset();
        m_rd1 = '0; m_rd2 = '0; m_or1 = '0; m_or2 = '0;
        m_rk1 = 1;  m_rk2 = 1;  m_ok1 = 1;  m_ok2 = 1;
        m_busy = CLR; m_coll = 0; m_cnt = 0;
        for (int k = 0; k < 64; k++) m_k[k] = 0;
    endtask

    task automatic model_edge();
        m_or1 = m_rd1; m_ok1 = m_rk1;
        m_or2 = m_rd2; m_ok2 = m_rk2;
        if (m_busy) begin
            m_rd1 = '0; m_rd2 = '0; m_rk1 = 1; m_rk2 = 1; m_coll = 0;
            m_mem[m_cnt] = '0; m_k[m_cnt] = 1;
            if (m_cnt == 63) m_busy = 0;
            else m_cnt++;
        end else begin
            if (!csb1 && web1) begin m_rd1 = m_mem[a1]; m_rk1 = m_k[a1]; end
            if (!csb2 && web2) begin m_rd2 = m_mem[a2]; m_rk2 = m_k[a2]; end
            m_coll = !csb1 && !web1 && !csb2 && !web2 && (a1 == a2);
            // Port 2 lands first so that port 1 overrides any bit both ports write.
            for (int b = 0; b < 32; b++) begin
                if (!csb2 && !web2 && !bweb2[b]) m_mem[a2][b] = i2[b];
                if (!csb1 && !web1 && !bweb1[b]) m_mem[a1][b] = i1[b];
            end
            if (!csb2 && !web2 && bweb2 == '0) m_k[a2] = 1;
            if (!csb1 && !web1 && bweb1 == '0) m_k[a1] = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_off(input string name, input logic [31:0] act);
        n_checks++;
        if (!(act === 'z || act === '0)) begin
            n_err++;
            $display("FAIL %s: got %h expected high-impedance at %0t", name, act, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy0", {31'b0, bus0.BUSY_i}, {31'b0, m_busy});
            chk("busy1", {31'b0, bus1.BUSY_i}, {31'b0, m_busy});
            chk("coll0", {31'b0, bus0.COLL_i}, {31'b0, m_coll});
            chk("coll1", {31'b0, bus1.COLL_i}, {31'b0, m_coll});
            if (oeb1) begin
                chk_off("o1_0_off", o1_0);
                chk_off("o1_1_off", o1_1);
            end else begin
                if (m_rk1) chk("o1_0", o1_0, m_rd1);
                if (m_ok1) chk("o1_1", o1_1, m_or1);
            end
            if (oeb2) begin
                chk_off("o2_0_off", o2_0);
                chk_off("o2_1_off", o2_1);
            end else begin
                if (m_rk2) chk("o2_0", o2_0, m_rd2);
                if (m_ok2) chk("o2_1", o2_1, m_or2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rstb) model_edge();
        #1;
    endtask

    task automatic idle();
        csb1 = 1; csb2 = 1; web1 = 1; web2 = 1;
        bweb1 = '0; bweb2 = '0; i1 = '0; i2 = '0;
    endtask

    task automatic p1_wr(input logic [5:0] a, input logic [31:0] d, input logic [31:0] m);
        csb1 = 0; web1 = 0; a1 = a; i1 = d; bweb1 = m;
    endtask

    task automatic p2_wr(input logic [5:0] a, input logic [31:0] d, input logic [31:0] m);
        csb2 = 0; web2 = 0; a2 = a; i2 = d; bweb2 = m;
    endtask

    task automatic p1_rd(input logic [5:0] a);
        csb1 = 0; web1 = 1; a1 = a;
    endtask

    task automatic p2_rd(input logic [5:0] a);
        csb2 = 0; web2 = 1; a2 = a;
    endtask

    task automatic sweep(input string name);
        int n;
        n = 0;
        while (bus0.BUSY_i && n < 200) begin
            tick();
            n++;
        end
        chk(name, n, CLR ? 64 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        oeb1 = 0; oeb2 = 0; a1 = '0; a2 = '0;
        rstb = 0;
        model_reset();
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o1_0", o1_0, 32'h0);
        chk("rst_o2_1", o2_1, 32'h0);
        chk("rst_busy", {31'b0, bus0.BUSY_i}, {31'b0, CLR});

        rstb = 1;
        sweep("sweep_len");

        // Seed words that the next sweep must clear.
        p1_wr(6'd0, 32'hCAFEF00D, '0); p2_wr(6'd17, 32'hCAFEF00D, '0); tick();
        idle(); p1_wr(6'd63, 32'hCAFEF00D, '0); tick();
        idle(); p2_rd(6'd17); tick();
        chk("seed_rd17", o2_0, 32'hCAFEF00D);
        idle();

        // Reset in the middle of the sweep restarts it from address 0.
        rstb = 0; model_reset(); @(posedge clk); #1;
        rstb = 1;
        repeat (30) tick();
        rstb = 0; model_reset(); #1;
        chk("midrst_busy", {31'b0, bus0.BUSY_i}, {31'b0, CLR});
        repeat (2) @(posedge clk);
        #1;
        rstb = 1;
        sweep("resweep_len");

`ifdef SRAM2RW_CLEAR_EN
        p1_rd(6'd0); p2_rd(6'd17); tick();
        chk("clr_a0", o1_0, 32'h0);
        chk("clr_a17", o2_0, 32'h0);
        idle(); p1_rd(6'd63); tick();
        chk("clr_a63", o1_0, 32'h0);
        idle();
`endif

        // Masked write.
        p1_wr(6'd5, 32'hFFFFFFFF, 32'h0); tick();
        p1_wr(6'd5, 32'h00000000, 32'hFFFF0000); tick();
        idle(); p2_rd(6'd5); tick();
        chk("mask_o2_0", o2_0, 32'hFFFF0000);
        idle(); tick();
        chk("mask_o2_1", o2_1, 32'hFFFF0000);

        // Read-first between ports.
        p2_wr(6'd9, 32'h12345678, '0); tick();
        idle(); p1_wr(6'd9, 32'hA5A5A5A5, '0); p2_rd(6'd9); tick();
        chk("rfirst_old", o2_0, 32'h12345678);
        idle(); p2_rd(6'd9); tick();
        chk("rfirst_new", o2_0, 32'hA5A5A5A5);

        // Full-mask and partial-mask collisions.
        idle(); p1_wr(6'd3, 32'h11111111, '0); p2_wr(6'd3, 32'h22222222, '0); tick();
        chk("coll_pulse", {31'b0, bus0.COLL_i}, 32'h1);
        idle(); tick();
        chk("coll_drop", {31'b0, bus0.COLL_i}, 32'h0);
        p1_rd(6'd3); tick();
        chk("coll_data", o1_0, 32'h11111111);
        idle(); p1_wr(6'd3, 32'hAAAAAAAA, 32'hFFFF0000); p2_wr(6'd3, 32'h55555555, 32'hFF0000FF); tick();
        idle(); p1_rd(6'd3); p2_rd(6'd3); tick();
        chk("pcoll_p1", o1_0, 32'h1155AAAA);
        chk("pcoll_p2", o2_0, 32'h1155AAAA);
        chk("dual_rd_nocoll", {31'b0, bus0.COLL_i}, 32'h0);

        // Output-stage latency: the registered copy trails by one edge.
        idle(); p1_rd(6'd5); tick();
        chk("lat_o1_0", o1_0, 32'hFFFF0000);
        chk("lat_o1_1_old", o1_1, 32'h1155AAAA);
        idle(); tick();
        chk("lat_o1_1_new", o1_1, 32'hFFFF0000);

        // OEB is combinational.
        oeb1 = 1; #1;
        chk_off("oeb_off_0", o1_0);
        chk_off("oeb_off_1", o1_1);
        oeb1 = 0; #1;
        chk("oeb_on_0", o1_0, 32'hFFFF0000);

        // Write then read-back on the following edge.
        p2_wr(6'd40, 32'hDEADBEEF, '0); tick();
        idle(); p1_rd(6'd40); tick();
        chk("wr_rd_0", o1_0, 32'hDEADBEEF);
        idle(); tick();
        chk("wr_rd_1", o1_1, 32'hDEADBEEF);

        // Mixed traffic, checked cycle by cycle against the reference.
        for (int k = 0; k < 8; k++) begin
            idle();
            p2_wr(6'(20 + k * 5), 32'h01010101 * (k + 1), '0);
            p1_rd(6'(20 + ((k + 7) % 8) * 5));
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            idle();
            p1_wr(6'(20 + k * 5), 32'hF0F0F0F0, (k % 2 == 0) ? 32'h0F0F0F0F : 32'hFFFF0000);
            p2_rd(6'(20 + k * 5));
            tick();
            idle(); p1_rd(6'(20 + k * 5)); tick();
        end

        // Asynchronous reset clears the outputs without waiting for an edge.
        idle(); p1_rd(6'd5); tick();
        rstb = 0; model_reset(); #1;
        chk("arst_o1_0", o1_0, 32'h0);
        chk("arst_o1_1", o1_1, 32'h0);
        @(posedge clk);
        #1;
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
